// File: rtl/mips_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Bundles the signals between the multicycle MIPS controller and its datapath.
//   Datapath -> controller : op, funct (from IR), zero, avsb (ALU flags),
//                            memready (memory completes the access this cycle)
//   Controller -> datapath : mux selects, write enables, alucontrol,
//                            retire pulse and halt status
// Modports:
//   master : the controller (drives the control word)
//   slave  : the datapath (drives opcode, flags and memready)
// ---------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       avsb;
  logic       memready;

  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic [1:0] memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       immzero;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       retire;
  logic       halt;

  modport master (
    input  op, funct, zero, avsb, memready,
    output iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, immzero, pcsrc, alucontrol, retire, halt
  );

  modport slave (
    output op, funct, zero, avsb, memready,
    input  iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, immzero, pcsrc, alucontrol, retire, halt
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore FSM that sequences a multicycle MIPS datapath (shared memory, single
// ALU, IR/A/B/ALUOut/Data holding registers). Supports R-type add/sub/and/or/
// slt/srl, jr, lw, lh, lhu, sw, beq, bgtz, addi, andi, xori and j. Memory
// states wait on memready; a watchdog traps a memory access that never ends.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : controller side of mips_multicycle_ctrl_if (see interface file)
// Parameters:
//   TIMEOUT : max cycles a memory state may wait (0 disables the watchdog)
//   CNT_W   : width of the wait counter, must hold TIMEOUT
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
    BEQ, BGTZ, IMMEX, IMMWB, JUMP, JR, TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b011;

  localparam bit             WD_ON = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             expire;
  logic             funct_ok;
  logic [2:0]       funct_alu;

  logic       iord_s, memwrite_s, irwrite_s, pcen_s, regwrite_s, regdst_s;
  logic [1:0] memtoreg_s, alusrcb_s, pcsrc_s;
  logic       alusrca_s, immzero_s, retire_s;
  logic [2:0] alucontrol_s;

  // Watchdog fires in the limit cycle of a stalled memory state; memready in
  // that same cycle still wins and completes the access normally.
  assign expire = WD_ON && !bus.memready && (cnt == LIMIT);

  // The wait counter restarts whenever the state changes, so it measures the
  // number of stalled cycles spent in the current memory state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        cnt <= '0;
      else if (!bus.memready)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // R-type funct decode, shared by DECODE (legality) and EXEC (ALU op).
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.funct)
      F_ADD:   funct_alu = ALU_ADD;
      F_SUB:   funct_alu = ALU_SUB;
      F_AND:   funct_alu = ALU_AND;
      F_OR:    funct_alu = ALU_OR;
      F_SLT:   funct_alu = ALU_SLT;
      F_SRL:   funct_alu = ALU_SRL;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (bus.memready)  state_next = DECODE;
        else if (expire)   state_next = TRAP;
      end
      DECODE: begin
        case (bus.op)
          OP_RTYPE: begin
            if (bus.funct == F_JR) state_next = JR;
            else if (funct_ok)     state_next = EXEC;
            else                   state_next = TRAP;
          end
          OP_LW, OP_LH, OP_LHU, OP_SW: state_next = MEMADR;
          OP_BEQ:                      state_next = BEQ;
          OP_BGTZ:                     state_next = BGTZ;
          OP_ADDI, OP_ANDI, OP_XORI:   state_next = IMMEX;
          OP_J:                        state_next = JUMP;
          default:                     state_next = TRAP;
        endcase
      end
      MEMADR: state_next = (bus.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD: begin
        if (bus.memready)  state_next = MEMWB;
        else if (expire)   state_next = TRAP;
      end
      MEMWR: begin
        if (bus.memready)  state_next = FETCH;
        else if (expire)   state_next = TRAP;
      end
      EXEC:   state_next = ALUWB;
      IMMEX:  state_next = IMMWB;
      MEMWB, ALUWB, BEQ, BGTZ, IMMWB, JUMP, JR: state_next = FETCH;
      TRAP:   state_next = TRAP;
      default: state_next = TRAP;
    endcase
  end

  // Control word per state. In FETCH/MEMWR the enables follow memready, so a
  // stalled or timed-out cycle never commits anything.
  always_comb begin
    iord_s       = 1'b0;
    memwrite_s   = 1'b0;
    irwrite_s    = 1'b0;
    pcen_s       = 1'b0;
    regwrite_s   = 1'b0;
    regdst_s     = 1'b0;
    memtoreg_s   = 2'b00;
    alusrca_s    = 1'b0;
    alusrcb_s    = 2'b00;
    immzero_s    = 1'b0;
    pcsrc_s      = 2'b00;
    alucontrol_s = ALU_ADD;
    retire_s     = 1'b0;
    case (state)
      FETCH: begin
        alusrcb_s = 2'b01;
        irwrite_s = bus.memready;
        pcen_s    = bus.memready;
      end
      DECODE: alusrcb_s = 2'b11;
      MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      MEMRD: iord_s = 1'b1;
      MEMWB: begin
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
        case (bus.op)
          OP_LH:   memtoreg_s = 2'b10;
          OP_LHU:  memtoreg_s = 2'b11;
          default: memtoreg_s = 2'b01;
        endcase
      end
      MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
        retire_s   = bus.memready;
      end
      EXEC: begin
        alusrca_s    = 1'b1;
        alucontrol_s = funct_alu;
      end
      ALUWB: begin
        regwrite_s = 1'b1;
        regdst_s   = 1'b1;
        retire_s   = 1'b1;
      end
      BEQ, BGTZ: begin
        alusrca_s    = 1'b1;
        alucontrol_s = ALU_SUB;
        pcsrc_s      = 2'b01;
        pcen_s       = (state == BEQ) ? bus.zero : bus.avsb;
        retire_s     = 1'b1;
      end
      IMMEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        case (bus.op)
          OP_ANDI: begin
            alucontrol_s = ALU_AND;
            immzero_s    = 1'b1;
          end
          OP_XORI: begin
            alucontrol_s = ALU_XOR;
            immzero_s    = 1'b1;
          end
          default: alucontrol_s = ALU_ADD;
        endcase
      end
      IMMWB: begin
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      JUMP: begin
        pcsrc_s  = 2'b10;
        pcen_s   = 1'b1;
        retire_s = 1'b1;
      end
      JR: begin
        pcsrc_s  = 2'b11;
        pcen_s   = 1'b1;
        retire_s = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural enables are masked while reset is held so an aborted
  // instruction cannot commit anything in the reset cycle.
  assign bus.iord       = iord_s;
  assign bus.memwrite   = memwrite_s & reset;
  assign bus.irwrite    = irwrite_s  & reset;
  assign bus.pcen       = pcen_s     & reset;
  assign bus.regwrite   = regwrite_s & reset;
  assign bus.regdst     = regdst_s;
  assign bus.memtoreg   = memtoreg_s;
  assign bus.alusrca    = alusrca_s;
  assign bus.alusrcb    = alusrcb_s;
  assign bus.immzero    = immzero_s;
  assign bus.pcsrc      = pcsrc_s;
  assign bus.alucontrol = alucontrol_s;
  assign bus.retire     = retire_s   & reset;
  assign bus.halt       = (state == TRAP);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Directed bench for mips_multicycle_ctrl (TIMEOUT=4). Each cycle drives the
// datapath-side inputs, then compares the full control word against a
// hand-derived expected word on the falling edge.
// Control word packing (MSB..LSB):
//   iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg[1:0], alusrca,
//   alusrcb[1:0], immzero, pcsrc[1:0], alucontrol[2:0], retire, halt
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl #(.TIMEOUT(4), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {bus.iord, bus.memwrite, bus.irwrite, bus.pcen, bus.regwrite,
                bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb,
                bus.immzero, bus.pcsrc, bus.alucontrol, bus.retire, bus.halt};

  function automatic logic [18:0] ov(
    input logic iord, memwrite, irwrite, pcen, regwrite, regdst,
    input logic [1:0] memtoreg, input logic alusrca, input logic [1:0] alusrcb,
    input logic immzero, input logic [1:0] pcsrc, input logic [2:0] alucontrol,
    input logic retire, halt);
    return {iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca,
            alusrcb, immzero, pcsrc, alucontrol, retire, halt};
  endfunction

  task automatic checkOutput(input string tag, input logic [18:0] actual,
                             input logic [18:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rst,
                               input logic mr, input logic z, input logic gt,
                               input logic [18:0] expected);
    reset        = rst;
    bus.memready = mr;
    bus.zero     = z;
    bus.avsb     = gt;
    @(negedge clk);
    checkOutput(tag, obs, expected);
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic [18:0] e_fetch_go, e_fetch_wait, e_decode, e_memadr, e_memrd;
  logic [18:0] e_memwr_wait, e_memwr_done, e_aluwb, e_immwb, e_trap;

  logic [5:0] r_funct [6];
  logic [2:0] r_alu   [6];
  logic [5:0] i_op    [3];
  logic [2:0] i_alu   [3];
  logic       i_zx    [3];

  initial begin
    e_fetch_go   = ov(0,0,1,1,0,0,2'b00,0,2'b01,0,2'b00,3'b010,0,0);
    e_fetch_wait = ov(0,0,0,0,0,0,2'b00,0,2'b01,0,2'b00,3'b010,0,0);
    e_decode     = ov(0,0,0,0,0,0,2'b00,0,2'b11,0,2'b00,3'b010,0,0);
    e_memadr     = ov(0,0,0,0,0,0,2'b00,1,2'b10,0,2'b00,3'b010,0,0);
    e_memrd      = ov(1,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,3'b010,0,0);
    e_memwr_wait = ov(1,1,0,0,0,0,2'b00,0,2'b00,0,2'b00,3'b010,0,0);
    e_memwr_done = ov(1,1,0,0,0,0,2'b00,0,2'b00,0,2'b00,3'b010,1,0);
    e_aluwb      = ov(0,0,0,0,1,1,2'b00,0,2'b00,0,2'b00,3'b010,1,0);
    e_immwb      = ov(0,0,0,0,1,0,2'b00,0,2'b00,0,2'b00,3'b010,1,0);
    e_trap       = ov(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,3'b010,0,1);

    r_funct = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000010};
    r_alu   = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b011};
    i_op    = '{6'b001000, 6'b001100, 6'b001110};
    i_alu   = '{3'b010,    3'b000,    3'b101};
    i_zx    = '{1'b0,      1'b1,      1'b1};

    reset = 1'b0;
    bus.op = 6'b000000;
    bus.funct = 6'b100000;
    bus.memready = 1'b1;
    bus.zero = 1'b0;
    bus.avsb = 1'b0;
    @(posedge clk);
    #1;

    // Reset held: FETCH with memready=1, but every enable masked.
    applyStimulus("reset_hold", 0, 1, 0, 0, e_fetch_wait);

    // R-type sweep, add first.
    for (int i = 0; i < 6; i++) begin
      bus.op = 6'b000000;
      bus.funct = r_funct[i];
      applyStimulus($sformatf("r%0d_fetch", i), 1, 1, 0, 0, e_fetch_go);
      applyStimulus($sformatf("r%0d_decode", i), 1, 1, 0, 0, e_decode);
      applyStimulus($sformatf("r%0d_exec", i), 1, 1, 0, 0,
                    ov(0,0,0,0,0,0,2'b00,1,2'b00,0,2'b00,r_alu[i],0,0));
      applyStimulus($sformatf("r%0d_aluwb", i), 1, 1, 0, 0, e_aluwb);
    end

    // Immediate ALU ops.
    for (int i = 0; i < 3; i++) begin
      bus.op = i_op[i];
      applyStimulus($sformatf("i%0d_fetch", i), 1, 1, 0, 0, e_fetch_go);
      applyStimulus($sformatf("i%0d_decode", i), 1, 1, 0, 0, e_decode);
      applyStimulus($sformatf("i%0d_immex", i), 1, 1, 0, 0,
                    ov(0,0,0,0,0,0,2'b00,1,2'b10,i_zx[i],2'b00,i_alu[i],0,0));
      applyStimulus($sformatf("i%0d_immwb", i), 1, 1, 0, 0, e_immwb);
    end

    // lh with a 1-cycle fetch stall and 3 stalled MEMRD cycles; the 4th
    // MEMRD cycle is the watchdog limit cycle but memready completes it.
    bus.op = 6'b100001;
    applyStimulus("lh_fetch_stall", 1, 0, 0, 0, e_fetch_wait);
    applyStimulus("lh_fetch", 1, 1, 0, 0, e_fetch_go);
    applyStimulus("lh_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("lh_memadr", 1, 1, 0, 0, e_memadr);
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("lh_memrd_wait%0d", i), 1, 0, 0, 0, e_memrd);
    applyStimulus("lh_memrd_limit", 1, 1, 0, 0, e_memrd);
    applyStimulus("lh_memwb", 1, 1, 0, 0, ov(0,0,0,0,1,0,2'b10,0,2'b00,0,2'b00,3'b010,1,0));

    bus.op = 6'b100101;
    applyStimulus("lhu_fetch", 1, 1, 0, 0, e_fetch_go);
    applyStimulus("lhu_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("lhu_memadr", 1, 1, 0, 0, e_memadr);
    applyStimulus("lhu_memrd", 1, 1, 0, 0, e_memrd);
    applyStimulus("lhu_memwb", 1, 1, 0, 0, ov(0,0,0,0,1,0,2'b11,0,2'b00,0,2'b00,3'b010,1,0));

    bus.op = 6'b100011;
    applyStimulus("lw_fetch", 1, 1, 0, 0, e_fetch_go);
    applyStimulus("lw_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("lw_memadr", 1, 1, 0, 0, e_memadr);
    applyStimulus("lw_memrd", 1, 1, 0, 0, e_memrd);
    applyStimulus("lw_memwb", 1, 1, 0, 0, ov(0,0,0,0,1,0,2'b01,0,2'b00,0,2'b00,3'b010,1,0));

    // Branches: beq follows zero only, bgtz follows avsb only.
    bus.op = 6'b000100;
    applyStimulus("beq_t_fetch", 1, 1, 0, 0, e_fetch_go);
    applyStimulus("beq_t_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("beq_taken", 1, 1, 1, 0, ov(0,0,0,1,0,0,2'b00,1,2'b00,0,2'b01,3'b110,1,0));
    applyStimulus("beq_n_fetch", 1, 1, 0, 0, e_fetch_go);
    applyStimulus("beq_n_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("beq_not", 1, 1, 0, 1, ov(0,0,0,0,0,0,2'b00,1,2'b00,0,2'b01,3'b110,1,0));
    bus.op = 6'b000111;
    applyStimulus("bgtz_t_fetch", 1, 1, 0, 0, e_fetch_go);
    applyStimulus("bgtz_t_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("bgtz_taken", 1, 1, 0, 1, ov(0,0,0,1,0,0,2'b00,1,2'b00,0,2'b01,3'b110,1,0));
    applyStimulus("bgtz_n_fetch", 1, 1, 0, 0, e_fetch_go);
    applyStimulus("bgtz_n_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("bgtz_not", 1, 1, 1, 0, ov(0,0,0,0,0,0,2'b00,1,2'b00,0,2'b01,3'b110,1,0));

    // Jumps.
    bus.op = 6'b000010;
    applyStimulus("j_fetch", 1, 1, 0, 0, e_fetch_go);
    applyStimulus("j_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("j_jump", 1, 1, 0, 0, ov(0,0,0,1,0,0,2'b00,0,2'b00,0,2'b10,3'b010,1,0));
    bus.op = 6'b000000;
    bus.funct = 6'b001000;
    applyStimulus("jr_fetch", 1, 1, 0, 0, e_fetch_go);
    applyStimulus("jr_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("jr_jr", 1, 1, 0, 0, ov(0,0,0,1,0,0,2'b00,0,2'b00,0,2'b11,3'b010,1,0));

    // sw with zero wait.
    bus.op = 6'b101011;
    applyStimulus("sw_fetch", 1, 1, 0, 0, e_fetch_go);
    applyStimulus("sw_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("sw_memadr", 1, 1, 0, 0, e_memadr);
    applyStimulus("sw_memwr", 1, 1, 0, 0, e_memwr_done);
    applyStimulus("sw_next_fetch", 1, 1, 0, 0, e_fetch_go);

    // sw timeout: memwrite for 4 stalled cycles, then absorbing TRAP.
    applyStimulus("swto_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("swto_memadr", 1, 1, 0, 0, e_memadr);
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("swto_memwr%0d", i), 1, 0, 0, 0, e_memwr_wait);
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("swto_trap%0d", i), 1, 1, 1, 1, e_trap);
    pulseReset();
    applyStimulus("swto_after_reset", 1, 1, 0, 0, e_fetch_go);

    // Illegal opcode and unsupported funct both trap after DECODE.
    bus.op = 6'b111111;
    applyStimulus("ill_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("ill_trap", 1, 1, 0, 0, e_trap);
    applyStimulus("ill_trap_hold", 1, 1, 0, 0, e_trap);
    pulseReset();
    bus.op = 6'b000000;
    bus.funct = 6'b111111;
    applyStimulus("badf_fetch", 1, 1, 0, 0, e_fetch_go);
    applyStimulus("badf_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("badf_trap", 1, 1, 0, 0, e_trap);
    pulseReset();

    // Reset during MEMWR: memwrite masked at once, FETCH after the edge.
    bus.op = 6'b101011;
    applyStimulus("swrst_fetch", 1, 1, 0, 0, e_fetch_go);
    applyStimulus("swrst_decode", 1, 1, 0, 0, e_decode);
    applyStimulus("swrst_memadr", 1, 1, 0, 0, e_memadr);
    applyStimulus("swrst_memwr", 1, 0, 0, 0, e_memwr_wait);
    applyStimulus("swrst_in_reset", 0, 0, 0, 0, ov(1,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,3'b010,0,0));
    applyStimulus("swrst_fetch_after", 1, 0, 0, 0, e_fetch_wait);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
